fp_divider_unit: RTL and testbench



---
 rtl/fp_div_pkg.sv | 26 ++
 rtl/fp_operand_class.sv | 25 ++
 rtl/fp_divider_unit.sv | 169 ++++++++++++++++
 tb/tb_fp_divider_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared types and constants for the iterative binary32 divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, casesspecial flag encodings, exponent bias,
// quiet-NaN pattern and the all-ones exponent value.
package fp_div_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIVIDE = 2'd1,
      ST_NORM   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // {Cero, +Inf, -Inf, NaN}; same encoding as the multiplier unit
   localparam logic [3:0] CS_ZERO   = 4'b1000;
   localparam logic [3:0] CS_PINF   = 4'b0100;
   localparam logic [3:0] CS_NINF   = 4'b0010;
   localparam logic [3:0] CS_NAN    = 4'b0001;
   localparam logic [3:0] CS_NORMAL = 4'b0000;

   localparam logic signed [9:0] BIAS    = 10'sd127;
   localparam logic [31:0]       QNAN    = 32'h7FC0_0000;
   localparam logic [7:0]        EXP_MAX = 8'hFF;

endpackage

// File: rtl/fp_operand_class.sv
// Classifies one binary32 operand as zero (denormals flushed), Inf or NaN.
// Latency: combinational.
// Backpressure: none.
// Ports: operand (32b in), is_zero / is_inf / is_nan (1b out each).
module fp_operand_class
   import fp_div_pkg::*;
(
   input  logic [31:0] operand,
   output logic        is_zero,
   output logic        is_inf,
   output logic        is_nan
);

   logic [7:0]  exp_f;
   logic [22:0] frac_f;

   assign exp_f  = operand[30:23];
   assign frac_f = operand[22:0];

   // exponent 0 covers both true zero and denormals, which are flushed
   assign is_zero = (exp_f == 8'h00);
   assign is_inf  = (exp_f == EXP_MAX) && (frac_f == 23'h0);
   assign is_nan  = (exp_f == EXP_MAX) && (frac_f != 23'h0);

endmodule

// File: rtl/fp_divider_unit.sv
// Iterative binary32 divider dataA / dataB, radix-2 restoring, truncating.
// Latency: done 26 edges after the accepting edge (specials: next cycle).
// Backpressure: start is only sampled in IDLE; starts while busy are dropped.
// Ports: clk, reset_n (async active-low), start, dataA, dataB in;
//        busy, done (1-cycle pulse), dataR (quotient), casesspecial out.
module fp_divider_unit
   import fp_div_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] dataA,
   input  logic [31:0] dataB,
   output logic        busy,
   output logic        done,
   output logic [31:0] dataR,
   output logic [3:0]  casesspecial
);

   state_t state, state_nxt;

   logic        sign_q;
   logic [7:0]  exp_a, exp_b;
   logic [23:0] mant_b;
   logic [24:0] rem;
   logic [24:0] quo;
   logic [4:0]  cnt;

   // ---------------- operand classification ----------------
   logic a_zero, a_inf, a_nan;
   logic b_zero, b_inf, b_nan;

   fp_operand_class u_class_a (
      .operand (dataA),
      .is_zero (a_zero),
      .is_inf  (a_inf),
      .is_nan  (a_nan)
   );

   fp_operand_class u_class_b (
      .operand (dataB),
      .is_zero (b_zero),
      .is_inf  (b_inf),
      .is_nan  (b_nan)
   );

   logic        sign_in;
   logic        sp_any;
   logic [31:0] sp_r;
   logic [3:0]  sp_cs;

   assign sign_in = dataA[31] ^ dataB[31];

   // first match wins: NaN, then Inf, then zero
   always_comb begin
      sp_any = 1'b1;
      sp_r   = 32'h0;
      sp_cs  = CS_NORMAL;
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
         sp_r  = QNAN;
         sp_cs = CS_NAN;
      end else if (a_inf || b_zero) begin
         sp_r  = {sign_in, EXP_MAX, 23'h0};
         sp_cs = sign_in ? CS_NINF : CS_PINF;
      end else if (a_zero || b_inf) begin
         sp_r  = {sign_in, 31'h0};
         sp_cs = CS_ZERO;
      end else begin
         sp_any = 1'b0;
      end
   end

   // ---------------- one restoring iteration ----------------
   logic        rem_ge;
   logic [24:0] rem_sub;
   logic [24:0] rem_next;

   assign rem_ge   = (rem >= {1'b0, mant_b});
   assign rem_sub  = rem_ge ? (rem - {1'b0, mant_b}) : rem;
   // rem_sub < mant_b < 2^24, so the shift never loses a set bit
   assign rem_next = rem_sub << 1;

   // ---------------- normalisation ----------------
   // mantissa ratio lies in (0.5, 2), so at most one position of adjustment
   logic signed [9:0] e_raw, e_adj;
   logic [22:0]       mant_n;
   logic [31:0]       norm_r;
   logic [3:0]        norm_cs;

   assign e_raw  = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + BIAS;
   assign e_adj  = quo[24] ? e_raw : (e_raw - 10'sd1);
   assign mant_n = quo[24] ? quo[23:1] : quo[22:0];

   always_comb begin
      norm_r  = {sign_q, e_adj[7:0], mant_n};
      norm_cs = CS_NORMAL;
      if (e_adj >= 10'sd255) begin
         norm_r  = {sign_q, EXP_MAX, 23'h0};
         norm_cs = sign_q ? CS_NINF : CS_PINF;
      end else if (e_adj <= 10'sd0) begin
         norm_r  = {sign_q, 31'h0};
         norm_cs = CS_ZERO;
      end
   end

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = (state != ST_IDLE);
      done      = (state == ST_DONE);
      case (state)
         ST_IDLE:   if (start) state_nxt = sp_any ? ST_DONE : ST_DIVIDE;
         ST_DIVIDE: if (cnt == 5'd0) state_nxt = ST_NORM;
         ST_NORM:   state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sign_q       <= 1'b0;
         exp_a        <= 8'h0;
         exp_b        <= 8'h0;
         mant_b       <= 24'h0;
         rem          <= 25'h0;
         quo          <= 25'h0;
         cnt          <= 5'd0;
         dataR        <= 32'h0;
         casesspecial <= 4'h0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  sign_q <= sign_in;
                  exp_a  <= dataA[30:23];
                  exp_b  <= dataB[30:23];
                  mant_b <= {1'b1, dataB[22:0]};
                  rem    <= {2'b01, dataA[22:0]};
                  quo    <= 25'h0;
                  cnt    <= 5'd24;
                  // specials skip the divide, so publish the result now
                  if (sp_any) begin
                     dataR        <= sp_r;
                     casesspecial <= sp_cs;
                  end
               end
            end
            ST_DIVIDE: begin
               quo <= {quo[23:0], rem_ge};
               rem <= rem_next;
               if (cnt != 5'd0) cnt <= cnt - 5'd1;
            end
            ST_NORM: begin
               dataR        <= norm_r;
               casesspecial <= norm_cs;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_divider_unit.sv
module tb_fp_divider_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [31:0] dataA, dataB;
   logic        busy, done;
   logic [31:0] dataR;
   logic [3:0]  casesspecial;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fp_divider_unit dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .dataA        (dataA),
      .dataB        (dataB),
      .busy         (busy),
      .done         (done),
      .dataR        (dataR),
      .casesspecial (casesspecial)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: classify by field values, divide the significands with one
   // integer division and normalise by the value of the integer part.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic [3:0] cs,
                                 output bit sp);
      int ea, eb, e;
      bit s, za, zb, ia, ib, na, nb;
      longint unsigned ma, mb, q, mant;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      s  = a[31] ^ b[31];
      za = (ea == 0);
      zb = (eb == 0);
      ia = (ea == 255) && (a[22:0] == 23'h0);
      ib = (eb == 255) && (b[22:0] == 23'h0);
      na = (ea == 255) && (a[22:0] != 23'h0);
      nb = (eb == 255) && (b[22:0] != 23'h0);
      sp = 1'b1;
      r  = 32'h0;
      cs = 4'b0000;
      if (na || nb || (za && zb) || (ia && ib)) begin
         r  = 32'h7FC00000;
         cs = 4'b0001;
      end else if (ia || zb) begin
         r  = {s, 8'hFF, 23'h0};
         cs = s ? 4'b0010 : 4'b0100;
      end else if (za || ib) begin
         r  = {s, 31'h0};
         cs = 4'b1000;
      end else begin
         sp = 1'b0;
         ma = 64'h800000 + longint'(a[22:0]);
         mb = 64'h800000 + longint'(b[22:0]);
         q  = (ma << 24) / mb;               // quotient with 24 fraction bits
         e  = ea - eb + 127;
         if (q >= 64'h1000000) mant = (q >> 1) & 64'h7FFFFF;
         else begin
            mant = q & 64'h7FFFFF;
            e    = e - 1;
         end
         if (e >= 255) begin
            r  = {s, 8'hFF, 23'h0};
            cs = s ? 4'b0010 : 4'b0100;
         end else if (e <= 0) begin
            r  = {s, 31'h0};
            cs = 4'b1000;
         end else begin
            r = {s, 8'(e), 23'(mant)};
         end
      end
   endfunction

   // drive operands with start for one edge; returns just after that edge
   task automatic accept(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      dataA = a;
      dataB = b;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // called on a negedge that is 'base' edges past the accepting edge
   task automatic wait_done(input int base, output int lat);
      lat = base;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic exec_check(input string tag, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] er;
      logic [3:0]  ecs;
      bit          sp;
      int          lat;
      model(a, b, er, ecs, sp);
      accept(a, b);
      @(negedge clk);
      wait_done(0, lat);
      // divides finish 26 edges after acceptance; specials in the next cycle
      chk({tag, "_lat"}, lat, sp ? 0 : 26);
      chk({tag, "_r"}, dataR, er);
      chk({tag, "_cs"}, {28'h0, casesspecial}, {28'h0, ecs});
      chk({tag, "_busy"}, {31'h0, busy}, 1);
      @(negedge clk);
      chk({tag, "_pulse"}, {31'h0, done}, 0);
   endtask

   function automatic logic [31:0] rand_operand();
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 9))
         0: v[30:23] = 8'h00;
         1: v[30:23] = 8'hFF;
         2: begin v[30:23] = 8'hFF; v[22:0] = 23'h0; end
         default: v[30:23] = 8'($urandom_range(1, 254));
      endcase
      return v;
   endfunction

   initial begin
      logic [31:0] er;
      logic [3:0]  ecs;
      bit          sp;
      int          lat;

      reset_n = 1'b0;
      start   = 1'b0;
      dataA   = 32'h0;
      dataB   = 32'h0;
      #1;
      chk("rst_busy", {31'h0, busy}, 0);
      chk("rst_done", {31'h0, done}, 0);
      chk("rst_r", dataR, 0);
      chk("rst_cs", {28'h0, casesspecial}, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      exec_check("norm", 32'h3FBD0000, 32'h3E400000);
      exec_check("neg", 32'hC32B0000, 32'h41180000);
      exec_check("trunc", 32'h3F800000, 32'h40400000);
      exec_check("pdiv0", 32'h40FC0000, 32'h00000000);
      exec_check("ndiv0", 32'hC0FC0000, 32'h00000000);
      exec_check("zz", 32'h00000000, 32'h00000000);
      exec_check("infinf", 32'h7F800000, 32'hFF800000);
      exec_check("zinf", 32'h00000000, 32'h7F800000);
      exec_check("ovf", 32'h7F000000, 32'h00800000);
      exec_check("unf", 32'h00800000, 32'h7F000000);
      exec_check("nanA", 32'h7FC12345, 32'h3F800000);

      // start pulsed mid-divide must be ignored
      model(32'h3FBD0000, 32'h3E400000, er, ecs, sp);
      accept(32'h3FBD0000, 32'h3E400000);
      repeat (5) @(negedge clk);
      dataA = 32'h40000000;
      dataB = 32'h3F800000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(5, lat);
      chk("ign_lat", lat, 26);
      chk("ign_r", dataR, er);
      chk("ign_cs", {28'h0, casesspecial}, {28'h0, ecs});
      @(negedge clk);

      // start held high: next op accepted in the IDLE cycle after DONE
      model(32'hC32B0000, 32'h41180000, er, ecs, sp);
      @(negedge clk);
      dataA = 32'hC32B0000;
      dataB = 32'h41180000;
      start = 1'b1;
      @(posedge clk);
      #1;
      dataA = 32'h3F800000;
      dataB = 32'h40400000;
      @(negedge clk);
      wait_done(0, lat);
      chk("b2b1_lat", lat, 26);
      chk("b2b1_r", dataR, er);
      @(negedge clk);
      chk("b2b_idle", {31'h0, busy}, 0);
      @(negedge clk);
      chk("b2b_reacc", {31'h0, busy}, 1);
      start = 1'b0;
      chk("b2b_hold_r", dataR, er);
      model(32'h3F800000, 32'h40400000, er, ecs, sp);
      wait_done(0, lat);
      chk("b2b2_lat", lat, 26);
      chk("b2b2_r", dataR, er);
      @(negedge clk);

      // asynchronous reset mid-divide (dataR currently non-zero)
      accept(32'h3FBD0000, 32'h3E400000);
      repeat (13) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("arst_busy", {31'h0, busy}, 0);
      chk("arst_done", {31'h0, done}, 0);
      chk("arst_r", dataR, 0);
      chk("arst_cs", {28'h0, casesspecial}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      exec_check("post_rst", 32'h3FBD0000, 32'h3E400000);

      for (int i = 0; i < 40; i++) begin
         exec_check($sformatf("rnd%0d", i), rand_operand(), rand_operand());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
